// File: rtl/trojan_chk_pkg.sv
// Shared constants, FSM encoding and golden/MISR functions for the vector checker.
package trojan_chk_pkg;

    localparam int unsigned MISR_W   = 4;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned NUM_VEC  = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SETTLE_W = 4;

    // x^4+x^3+1: rotate left, with s3 also folded back into bit 3
    localparam logic [MISR_W-1:0] MISR_FB_MASK = 4'b1000;

    localparam int unsigned RESP_E = 3;
    localparam int unsigned RESP_F = 2;
    localparam int unsigned RESP_G = 1;
    localparam int unsigned RESP_H = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    // Expected {E,F,G,H} for vector idx = {A,B,C}
    function automatic logic [MISR_W-1:0] golden_resp(input logic [IDX_W-1:0] idx);
        logic a, b, c;
        logic [MISR_W-1:0] r;
        a = idx[2];
        b = idx[1];
        c = idx[0];
        r         = '0;
        r[RESP_E] = a & b;
        r[RESP_F] = a | c;
        r[RESP_G] = ~c;
        r[RESP_H] = a & b & c;
        return r;
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                    input logic [MISR_W-1:0] r);
        return {s[MISR_W-2:0], s[MISR_W-1]} ^ (MISR_FB_MASK & {MISR_W{s[MISR_W-1]}}) ^ r;
    endfunction

endpackage

// File: rtl/trojan_vector_checker_if.sv
// Stimulus/response bus between the checker and the circuit under test.
interface trojan_vector_checker_if;
    logic dut_a;
    logic dut_b;
    logic dut_c;
    logic dut_e;
    logic dut_f;
    logic dut_g;
    logic dut_h;

    modport master (output dut_a, dut_b, dut_c, input dut_e, dut_f, dut_g, dut_h);
    modport slave  (input dut_a, dut_b, dut_c, output dut_e, dut_f, dut_g, dut_h);
endinterface

// File: rtl/trojan_vector_checker_misr4.sv
// 4-bit MISR compacting captured responses; reset and load both restore the seed.
module misr4
    import trojan_chk_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [MISR_W-1:0] seed,
    input  logic              en,
    input  logic [MISR_W-1:0] r,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_sig <= seed;
        end else if (en) begin
            r_sig <= misr_step(r_sig, r);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/trojan_vector_checker.sv
// Exhaustive 3-input vector applier with golden compare and MISR signature.
module trojan_vector_checker
    import trojan_chk_pkg::*;
#(
    parameter int unsigned       SETTLE_CYCLES = 1,
    parameter logic [MISR_W-1:0] GOLDEN_SIG    = 4'h3,
    parameter logic [MISR_W-1:0] MISR_SEED     = 4'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    trojan_vector_checker_if.master      dut_if,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CNT_W-1:0]             mismatch_count,
    output logic [IDX_W-1:0]             first_fail_idx,
    output logic [MISR_W-1:0]            signature
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx,    w_idx_nxt;
    logic [SETTLE_W-1:0] r_settle, w_settle_nxt;
    logic [IDX_W-1:0]    r_abc,    w_abc_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_done,   w_done_nxt;
    logic                r_pass,   w_pass_nxt;
    logic [CNT_W-1:0]    r_mcnt,   w_mcnt_nxt;
    logic [IDX_W-1:0]    r_ffi,    w_ffi_nxt;
    logic                w_misr_load;
    logic                w_misr_en;
    logic [MISR_W-1:0]   w_sig;
    logic [MISR_W-1:0]   w_sig_upd;
    logic [MISR_W-1:0]   w_resp;
    logic                w_fail;

    always_comb begin
        w_resp         = '0;
        w_resp[RESP_E] = dut_if.dut_e;
        w_resp[RESP_F] = dut_if.dut_f;
        w_resp[RESP_G] = dut_if.dut_g;
        w_resp[RESP_H] = dut_if.dut_h;
    end

    assign w_fail    = (w_resp != golden_resp(r_idx));
    assign w_sig_upd = misr_step(w_sig, w_resp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for every registered output
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_settle_nxt = r_settle;
        w_abc_nxt    = '0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_pass_nxt   = r_pass;
        w_mcnt_nxt   = r_mcnt;
        w_ffi_nxt    = r_ffi;
        w_misr_load  = 1'b0;
        w_misr_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_APPLY;
                    w_idx_nxt    = '0;
                    w_settle_nxt = '0;
                    w_busy_nxt   = 1'b1;
                    w_pass_nxt   = 1'b0;
                    w_mcnt_nxt   = '0;
                    w_ffi_nxt    = '0;
                    w_misr_load  = 1'b1;
                end
            end
            ST_APPLY: begin
                w_busy_nxt = 1'b1;
                w_abc_nxt  = r_idx;
                if (r_settle == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt  = ST_CAPTURE;
                    w_settle_nxt = '0;
                end else begin
                    w_settle_nxt = SETTLE_W'(r_settle + 1'b1);
                end
            end
            ST_CAPTURE: begin
                w_misr_en = 1'b1;
                if (w_fail) begin
                    w_mcnt_nxt = CNT_W'(r_mcnt + 1'b1);
                    if (r_mcnt == '0) begin
                        w_ffi_nxt = r_idx;
                    end
                end
                if (r_idx == IDX_W'(NUM_VEC - 1)) begin
                    w_state_nxt = ST_FINISH;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_mcnt_nxt == '0) && (w_sig_upd == GOLDEN_SIG);
                end else begin
                    w_state_nxt = ST_APPLY;
                    w_idx_nxt   = IDX_W'(r_idx + 1'b1);
                    w_abc_nxt   = IDX_W'(r_idx + 1'b1);
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_settle <= '0;
            r_abc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_mcnt   <= '0;
            r_ffi    <= '0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_settle <= w_settle_nxt;
            r_abc    <= w_abc_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
            r_mcnt   <= w_mcnt_nxt;
            r_ffi    <= w_ffi_nxt;
        end
    end

    misr4 u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (w_misr_load),
        .seed (MISR_SEED),
        .en   (w_misr_en),
        .r    (w_resp),
        .sig  (w_sig)
    );

    assign dut_if.dut_a   = r_abc[2];
    assign dut_if.dut_b   = r_abc[1];
    assign dut_if.dut_c   = r_abc[0];
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign mismatch_count = r_mcnt;
    assign first_fail_idx = r_ffi;
    assign signature      = w_sig;

endmodule
